// File: rtl/decode_pkg.sv
// Shared encodings for the 10-bit decode/control unit: opcodes, FSM states,
// ALU/PC select codes and the per-opcode control vector.
package decode_pkg;

  localparam logic [3:0] OP_RESULT       = 4'd0;
  localparam logic [3:0] OP_SET_IMM      = 4'd1;
  localparam logic [3:0] OP_LOAD_QUERY   = 4'd2;
  localparam logic [3:0] OP_COMPARE      = 4'd3;
  localparam logic [3:0] OP_JUMP_BACK    = 4'd4;
  localparam logic [3:0] OP_INCREMENT    = 4'd5;
  localparam logic [3:0] OP_IF_DONE      = 4'd6;
  localparam logic [3:0] OP_STORE_ZERO   = 4'd7;
  localparam logic [3:0] OP_SET_ARG      = 4'd8;
  localparam logic [3:0] OP_JUMP_FP      = 4'd9;
  localparam logic [3:0] OP_SKIP_NOT_ONE = 4'd10;
  localparam logic [3:0] OP_PUSH         = 4'd11;
  localparam logic [3:0] OP_POP          = 4'd12;
  localparam logic [3:0] OP_SET_TEMP     = 4'd13;
  localparam logic [3:0] OP_RETURN       = 4'd14;
  localparam logic [3:0] OP_ILLEGAL      = 4'd15;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_e;

  typedef enum logic [2:0] {
    ALU_NOP      = 3'd0,
    ALU_PASS_IMM = 3'd1,
    ALU_CMP      = 3'd2,
    ALU_INC      = 3'd3,
    ALU_PASS_REG = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {PC_INC, PC_SKIP, PC_JUMP, PC_RET} pc_sel_e;

  // Conditional skips resolve against cond_flag while in EXEC.
  typedef enum logic [1:0] {COND_NONE, COND_SKIP_IF_SET, COND_SKIP_IF_CLEAR} cond_e;

  typedef struct packed {
    alu_op_e alu_op;
    pc_sel_e pc_sel;
    logic    pc_we;
    cond_e   cond;
    logic    sp_inc;
    logic    sp_dec;
    logic    mem_op;
    logic    mem_we;
    logic    reg_we;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_control_lut.sv
// Purely combinational opcode -> control vector table; the FSM gates the
// result by state.
module decode_control_lut
  import decode_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  logic [3:0] op4;
  logic       upper_set;

  assign op4       = opcode[3:0];
  assign upper_set = (opcode >> 4) != '0;

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    ctrl = '0;
    if (upper_set) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (op4)
        OP_RESULT:       begin ctrl.pc_we = 1'b1; ctrl.pc_sel = PC_INC; end
        OP_SET_IMM:      begin ctrl.alu_op = ALU_PASS_IMM; ctrl.reg_we = 1'b1; end
        OP_LOAD_QUERY:   begin ctrl.mem_op = 1'b1; ctrl.reg_we = 1'b1; end
        OP_COMPARE:      ctrl.alu_op = ALU_CMP;
        OP_JUMP_BACK:    begin ctrl.pc_sel = PC_JUMP; ctrl.pc_we = 1'b1; end
        OP_INCREMENT:    begin ctrl.alu_op = ALU_INC; ctrl.reg_we = 1'b1; end
        OP_IF_DONE:      begin ctrl.pc_we = 1'b1; ctrl.cond = COND_SKIP_IF_SET; end
        OP_STORE_ZERO:   begin ctrl.mem_op = 1'b1; ctrl.mem_we = 1'b1; end
        OP_SET_ARG:      begin ctrl.alu_op = ALU_PASS_REG; ctrl.reg_we = 1'b1; end
        OP_JUMP_FP:      begin ctrl.pc_sel = PC_JUMP; ctrl.pc_we = 1'b1; end
        OP_SKIP_NOT_ONE: begin ctrl.pc_we = 1'b1; ctrl.cond = COND_SKIP_IF_CLEAR; end
        OP_PUSH:         begin ctrl.sp_inc = 1'b1; ctrl.mem_op = 1'b1; ctrl.mem_we = 1'b1; end
        OP_POP:          begin ctrl.sp_dec = 1'b1; ctrl.mem_op = 1'b1; ctrl.reg_we = 1'b1; end
        OP_SET_TEMP:     begin ctrl.alu_op = ALU_PASS_IMM; ctrl.reg_we = 1'b1; end
        OP_RETURN:       begin ctrl.pc_sel = PC_RET; ctrl.pc_we = 1'b1; end
        default:         ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/decode_control_fsm.sv
// Multi-cycle decode/control FSM: IDLE -> DECODE -> EXEC -> [MEM] -> WB,
// with flush, memory timeout and illegal-opcode reporting.
module decode_control_fsm
  import decode_pkg::*;
#(
  parameter int INSTR_W     = 10,
  parameter int OPCODE_W    = 4,
  parameter int REG_AW      = 2,
  parameter int IMM_W       = INSTR_W - OPCODE_W,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               flush,
  input  logic               cond_flag,
  input  logic               mem_ack,
  output logic [REG_AW-1:0]  reg_raddr,
  output logic [REG_AW-1:0]  reg_waddr,
  output logic               reg_we,
  output logic [IMM_W-1:0]   imm_out,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_sel,
  output logic               pc_we,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic               mem_req,
  output logic               mem_we,
  output logic               flag_bit0,
  output logic               done,
  output logic               illegal,
  output logic               mem_timeout
);

  localparam int              CNT_W         = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [REG_AW-1:0]   reg_idx_q, reg_idx_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic                flag_q, flag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic    ready_q, ready_d;
  logic    reg_we_q, reg_we_d;
  alu_op_e alu_op_q, alu_op_d;
  pc_sel_e pc_sel_q, pc_sel_d;
  cond_e   cond_q, cond_d;
  logic    pc_we_q, pc_we_d;
  logic    sp_inc_q, sp_inc_d;
  logic    sp_dec_q, sp_dec_d;
  logic    mem_req_q, mem_req_d;
  logic    mem_we_q, mem_we_d;
  logic    done_q, done_d;
  logic    illegal_q, illegal_d;
  logic    timeout_q, timeout_d;

  ctrl_t ctrl;
  logic  timeout_hit;

  decode_control_lut #(.OPCODE_W(OPCODE_W)) u_lut (
    .opcode (opcode_q),
    .ctrl   (ctrl)
  );

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    reg_idx_d   = reg_idx_q;
    imm_d       = imm_q;
    flag_d      = flag_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_valid && !flush) begin
          opcode_d  = instr[INSTR_W-1 -: OPCODE_W];
          reg_idx_d = instr[INSTR_W-OPCODE_W-1 -: REG_AW];
          imm_d     = instr[IMM_W-1:0];
          flag_d    = instr[0];
          state_d   = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        cnt_d   = '0;
        state_d = ctrl.mem_op ? MEM : WB;
      end
      MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          state_d = WB;
        end else if (cnt_d == TIMEOUT_LIMIT) begin
          state_d     = WB;
          timeout_hit = 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush && state_q != IDLE) state_d = IDLE;

    // Outputs are decoded from the next state so they register in step with it.
    ready_d   = (state_d == IDLE);
    reg_we_d  = 1'b0;
    alu_op_d  = ALU_NOP;
    pc_sel_d  = PC_INC;
    cond_d    = COND_NONE;
    pc_we_d   = 1'b0;
    sp_inc_d  = 1'b0;
    sp_dec_d  = 1'b0;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    case (state_d)
      EXEC: begin
        alu_op_d = ctrl.alu_op;
        pc_sel_d = ctrl.pc_sel;
        cond_d   = ctrl.cond;
        pc_we_d  = ctrl.pc_we;
        sp_inc_d = ctrl.sp_inc;
        sp_dec_d = ctrl.sp_dec;
      end
      MEM: begin
        mem_req_d = 1'b1;
        mem_we_d  = ctrl.mem_we;
      end
      WB: begin
        done_d    = 1'b1;
        reg_we_d  = ctrl.reg_we && !timeout_hit;
        illegal_d = ctrl.illegal;
        timeout_d = timeout_hit;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears outputs without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      reg_idx_q <= '0;
      imm_q     <= '0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      reg_we_q  <= 1'b0;
      alu_op_q  <= ALU_NOP;
      pc_sel_q  <= PC_INC;
      cond_q    <= COND_NONE;
      pc_we_q   <= 1'b0;
      sp_inc_q  <= 1'b0;
      sp_dec_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      reg_idx_q <= reg_idx_d;
      imm_q     <= imm_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      reg_we_q  <= reg_we_d;
      alu_op_q  <= alu_op_d;
      pc_sel_q  <= pc_sel_d;
      cond_q    <= cond_d;
      pc_we_q   <= pc_we_d;
      sp_inc_q  <= sp_inc_d;
      sp_dec_q  <= sp_dec_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // cond_flag is only known during EXEC itself, so the skip select bypasses the register.
  always_comb begin
    pc_sel = pc_sel_q;
    if ((cond_q == COND_SKIP_IF_SET && cond_flag) ||
        (cond_q == COND_SKIP_IF_CLEAR && !cond_flag))
      pc_sel = PC_SKIP;
  end

  assign instr_ready = ready_q;
  assign reg_raddr   = reg_idx_q;
  assign reg_waddr   = reg_idx_q;
  assign reg_we      = reg_we_q;
  assign imm_out     = imm_q;
  assign alu_op      = alu_op_q;
  assign pc_we       = pc_we_q;
  assign sp_inc      = sp_inc_q;
  assign sp_dec      = sp_dec_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign flag_bit0   = flag_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_decode_control_fsm.sv
// Self-checking bench for decode_control_fsm: directed cases plus randomized
// instructions checked cycle by cycle against a per-opcode timeline model.
module tb_decode_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instr;
  logic       instr_valid, instr_ready, flush, cond_flag, mem_ack;
  logic [1:0] reg_raddr, reg_waddr;
  logic       reg_we;
  logic [5:0] imm_out;
  logic [2:0] alu_op;
  logic [1:0] pc_sel;
  logic       pc_we, sp_inc, sp_dec, mem_req, mem_we, flag_bit0, done, illegal, mem_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Last accepted instruction fields as the model sees them.
  logic [1:0] fld_reg  = '0;
  logic [5:0] fld_imm  = '0;
  logic       fld_flag = 1'b0;

  decode_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .cond_flag(cond_flag),
    .mem_ack(mem_ack), .reg_raddr(reg_raddr), .reg_waddr(reg_waddr),
    .reg_we(reg_we), .imm_out(imm_out), .alu_op(alu_op), .pc_sel(pc_sel),
    .pc_we(pc_we), .sp_inc(sp_inc), .sp_dec(sp_dec), .mem_req(mem_req),
    .mem_we(mem_we), .flag_bit0(flag_bit0), .done(done), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {instr_ready, reg_we, reg_waddr, reg_raddr, alu_op, pc_sel, pc_we,
                sp_inc, sp_dec, mem_req, mem_we, done, illegal, mem_timeout,
                flag_bit0, imm_out};

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (rdy,we,wa,ra,alu,pcs,pcwe,spi,spd,req,mwe,dn,ill,tmo,f0,imm)",
               tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [25:0] expv(input bit rdy, input bit we, input logic [2:0] alu,
                                       input logic [1:0] pcs, input bit pcwe, input bit spi,
                                       input bit spd, input bit mreq, input bit mwe,
                                       input bit dn, input bit ill, input bit tmo);
    return {rdy, we, fld_reg, fld_reg, alu, pcs, pcwe, spi, spd, mreq, mwe, dn, ill, tmo,
            fld_flag, fld_imm};
  endfunction

  function automatic logic [25:0] idle_exp();
    return expv(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Opcode semantics straight from the instruction table.
  function automatic bit op_is_mem(input int op);   return op inside {2, 7, 11, 12}; endfunction
  function automatic bit op_mem_wr(input int op);   return op inside {7, 11}; endfunction
  function automatic bit op_writes(input int op);   return op inside {1, 2, 5, 8, 12, 13}; endfunction
  function automatic bit op_pc_we(input int op);    return op inside {0, 4, 6, 9, 10, 14}; endfunction
  function automatic logic [2:0] op_alu(input int op);
    case (op)
      1, 13:   return 3'd1;
      3:       return 3'd2;
      5:       return 3'd3;
      8:       return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [1:0] op_pc_sel(input int op, input bit cf);
    case (op)
      4, 9:    return 2'd2;
      14:      return 2'd3;
      6:       return cf ? 2'd1 : 2'd0;
      10:      return cf ? 2'd0 : 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // One instruction from acceptance to the first idle cycle afterwards.
  // ack_at: MEM cycle carrying mem_ack (0 = never). flush_at: cycle offset
  // with flush high (0 = none). cf_force: cond_flag during EXEC (-1 = random).
  task automatic run_instr(input string name, input logic [9:0] ins, input int ack_at,
                           input int flush_at_in, input int cf_force);
    int  op, mem_len, k_done, k_end, flush_at;
    bit  is_mem, tmo, cf_exec;
    logic [25:0] e;
    op       = int'(ins[9:6]);
    is_mem   = op_is_mem(op);
    mem_len  = (ack_at != 0) ? ack_at : 15;
    tmo      = is_mem && (ack_at == 0);
    k_done   = is_mem ? 3 + mem_len : 3;
    flush_at = (flush_at_in > k_done) ? 0 : flush_at_in;
    k_end    = (flush_at != 0) ? flush_at + 1 : k_done + 1;
    cf_exec  = 1'b0;

    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1; flush = 1'b0;
    mem_ack = 1'($urandom_range(0, 1)); cond_flag = 1'($urandom_range(0, 1));
    @(negedge clk);
    check($sformatf("%s accept", name), obs, idle_exp());
    fld_reg = ins[5:4]; fld_imm = ins[5:0]; fld_flag = ins[0];

    for (int k = 1; k <= k_end; k++) begin
      @(posedge clk); #1;
      instr       = 10'($urandom);
      instr_valid = (k < k_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      flush       = (k == flush_at);
      cond_flag   = (k == 2 && cf_force >= 0) ? cf_force[0] : 1'($urandom_range(0, 1));
      if (is_mem && k >= 3 && k <= 2 + mem_len) mem_ack = (ack_at != 0) && (k == 2 + ack_at);
      else if (k < k_end)                     mem_ack = 1'($urandom_range(0, 1));
      else                                    mem_ack = 1'b0;
      if (k == 2) cf_exec = cond_flag;
      @(negedge clk);
      if ((flush_at != 0 && k > flush_at) || k > k_done)
        e = idle_exp();
      else if (k == 2)
        e = expv(1'b0, 1'b0, op_alu(op), op_pc_sel(op, cf_exec), op_pc_we(op),
                 op == 11, op == 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (k == k_done)
        e = expv(1'b0, op_writes(op) && !tmo, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, op == 15, tmo);
      else if (is_mem && k >= 3)
        e = expv(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, op_mem_wr(op),
                 1'b0, 1'b0, 1'b0);
      else
        e = expv(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("%s k%0d", name, k), obs, e);
    end
    flush = 1'b0;
  endtask

  task automatic flush_in_idle();
    @(posedge clk); #1;
    instr = 10'b0001_11_1111; instr_valid = 1'b1; flush = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    check("flush_idle same", obs, idle_exp());
    @(posedge clk); #1;
    instr_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle blocked", obs, idle_exp());
  endtask

  task automatic reset_mid_exec();
    @(posedge clk); #1;
    instr = 10'b0101_01_0111; instr_valid = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    fld_reg = 2'd1; fld_imm = 6'h17; fld_flag = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre exec", obs, expv(1'b0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    fld_reg = '0; fld_imm = '0; fld_flag = 1'b0;
    #1 check("rst_async", obs, idle_exp());
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release", obs, idle_exp());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; flush = 1'b0; cond_flag = 1'b0; mem_ack = 1'b0;
    #3 check("reset", obs, idle_exp());
    @(posedge clk); #1 rst = 1'b0;

    run_instr("set_imm",     10'b0001_10_1011, 0, 0, -1);
    run_instr("push",        10'b1011_01_0011, 3, 0, -1);
    run_instr("load_tmo",    10'b0010_11_0101, 0, 0, -1);
    run_instr("load_ack15",  10'b0010_01_0100, 15, 0, -1);
    run_instr("skipn1_cf0",  10'b1010_00_0000, 0, 0, 0);
    run_instr("skipn1_cf1",  10'b1010_00_0001, 0, 0, 1);
    run_instr("ifdone_cf1",  10'b0110_10_0010, 0, 0, 1);
    run_instr("illegal",     10'b1111_00_0001, 0, 0, -1);
    run_instr("pop_flush",   10'b1100_10_0000, 0, 4, -1);
    flush_in_idle();
    reset_mid_exec();

    for (int i = 0; i < 40; i++) begin
      logic [9:0] ins;
      int ack, fl;
      ins = {4'($urandom_range(0, 15)), 6'($urandom)};
      ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_instr($sformatf("rand%0d", i), ins, ack, fl, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
